// File: rtl/part_4.sv
// part_4: registered 6-bit input classifier.
// outBus = {parity, nonZero, msbIndex[2:0]}, one cycle after sampling.
module part_4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] inpBus,
  output logic [4:0] outBus
);

  function automatic logic parityOf(input logic [5:0] v);
    return ^v;
  endfunction

  function automatic logic nonZero(input logic [5:0] v);
    return |v;
  endfunction

  // Highest set bit wins; an all-zero word encodes as 0.
  function automatic logic [2:0] msbIndex(input logic [5:0] v);
    logic [2:0] idx;
    casez (v)
      6'b1?????: idx = 3'd5;
      6'b01????: idx = 3'd4;
      6'b001???: idx = 3'd3;
      6'b0001??: idx = 3'd2;
      6'b00001?: idx = 3'd1;
      default:   idx = 3'd0;
    endcase
    return idx;
  endfunction

  logic [4:0] nextOut;

  // Assemble the classification word from the live input.
  always_comb begin
    nextOut = {parityOf(inpBus), nonZero(inpBus), msbIndex(inpBus)};
  end

  // Output register; cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) outBus <= 5'b00000;
    else       outBus <= nextOut;
  end

endmodule

// File: tb/tb_part_4.sv
// tb_part_4: scoreboard bench for part_4.
// Stimulus queues expected words; a monitor pops one per clock.
`timescale 1ns/100ps
module tb_part_4;

  logic       clk;
  logic       reset;
  logic [5:0] inpBus;
  logic [4:0] outBus;

  int nChecks = 0;
  int nFails  = 0;
  logic [4:0] expQ[$];
  bit done = 0;

  part_4 dut (
    .clk    (clk),
    .reset  (reset),
    .inpBus (inpBus),
    .outBus (outBus)
  );

  initial clk = 0;
  always #10 clk = ~clk;

  // Independent reference: count ones and scan for highest set bit.
  function automatic logic [4:0] model(input logic [5:0] v);
    int ones = 0;
    int top  = 0;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) begin
        ones++;
        top = i;
      end
    end
    return {ones % 2 == 1, v != 6'd0, 3'(top)};
  endfunction

  task automatic check(input string name,
                       input logic [4:0] got,
                       input logic [4:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("FAIL %s: outBus=%b expected=%b at %0t",
               name, got, want, $time);
    end
  endtask

  // Drive one input at the falling edge and queue its result.
  task automatic step(input logic [5:0] v, input logic [4:0] want);
    @(negedge clk);
    inpBus = v;
    expQ.push_back(want);
  endtask

  // Monitor: every result is due just after the rising edge.
  initial begin
    logic [4:0] want;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        want = expQ.pop_front();
        check("scoreboard", outBus, want);
      end
    end
  end

  // Watchdog bounds the run.
  initial begin
    #200000;
    nFails++;
    $display("FAIL watchdog: done=%0d expected=1", done);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

  logic [5:0] vecIn  [11];
  logic [4:0] vecOut [11];

  initial begin
    vecIn[0]  = 6'b000000; vecOut[0]  = 5'b00000;
    vecIn[1]  = 6'b000001; vecOut[1]  = 5'b11000;
    vecIn[2]  = 6'b000010; vecOut[2]  = 5'b11001;
    vecIn[3]  = 6'b000011; vecOut[3]  = 5'b01001;
    vecIn[4]  = 6'b000111; vecOut[4]  = 5'b11010;
    vecIn[5]  = 6'b100000; vecOut[5]  = 5'b11101;
    vecIn[6]  = 6'b111111; vecOut[6]  = 5'b01101;
    vecIn[7]  = 6'b011111; vecOut[7]  = 5'b11100;
    vecIn[8]  = 6'b000000; vecOut[8]  = 5'b00000;
    vecIn[9]  = 6'b101010; vecOut[9]  = 5'b11101;
    vecIn[10] = 6'b000000; vecOut[10] = 5'b00000;

    reset  = 1;
    inpBus = 6'd0;
    #1;
    check("power-on reset", outBus, 5'b00000);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset hold", outBus, 5'b00000);
    end
    @(negedge clk);
    reset = 0;

    // Make outBus nonzero, then reset between edges.
    step(6'b111111, 5'b01101);
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    check("async reset", outBus, 5'b00000);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset 2 cycles", outBus, 5'b00000);
    end
    @(negedge clk);
    reset = 0;

    // Hand vectors: spot values, top bits, one-cycle pulse.
    for (int i = 0; i < 11; i++)
      step(vecIn[i], vecOut[i]);

    // Ramp with wrap and a reset pulse at 6'b010110.
    for (int n = 0; n < 100; n++) begin
      step(6'(n % 64), model(6'(n % 64)));
      if (n == 22) begin
        @(posedge clk);
        #2;
        reset = 1;
        #1;
        check("mid-run reset", outBus, 5'b00000);
        #2;
        reset = 0;
      end
    end

    repeat (3) @(posedge clk);
    #2;
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("FAIL drain: queued=%0d expected=0", expQ.size());
    end
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
